// File: rtl/rgb_led_arbiter_if.sv
// rgb_led_arbiter_if: request/grant bundle between the colour sources and
// the RGB LED arbiter.
//   req   : per-requester level request           (master -> slave)
//   color : requester i colour at [3i+2:3i], R/G/B (master -> slave)
//   grant : registered one-hot owner, 0 when idle  (slave -> master)
//   busy  : high while any grant is active         (slave -> master)
interface rgb_led_arbiter_if #(
    parameter int N_REQ = 3
);
    logic [N_REQ-1:0]   req;
    logic [3*N_REQ-1:0] color;
    logic [N_REQ-1:0]   grant;
    logic               busy;

    modport master (output req, color, input grant, busy);
    modport slave  (input req, color, output grant, busy);
endinterface

// File: rtl/rgb_led_arbiter.sv
// rgb_led_arbiter: shares the board RGB LED between N_REQ requesters with
// round-robin arbitration, a minimum display time per grant and a maximum
// hold time after which a waiting requester preempts the owner.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   bus (slave)       : req/color in, grant/busy out (registered)
//   RGB_R/RGB_G/RGB_B : active-low LED pins, registered
//   dim               : brightness, only when RGB_PWM_DIM_EN is defined
// Optional feature macro: RGB_PWM_DIM_EN (PWM dimming via dim/pwm_cnt).
module rgb_led_arbiter #(
    parameter int N_REQ    = 3,
    parameter int MIN_HOLD = 1200000,
    parameter int MAX_HOLD = 12000000,
    parameter int PWM_BITS = 4
) (
    input  logic              clk,
    input  logic              rst,
    rgb_led_arbiter_if.slave  bus,
`ifdef RGB_PWM_DIM_EN
    input  logic [PWM_BITS-1:0] dim,
`endif
    output logic              RGB_R,
    output logic              RGB_G,
    output logic              RGB_B
);
    localparam int HW = $clog2(MAX_HOLD);
    localparam int OW = $clog2(N_REQ);

    typedef enum logic {IDLE, OWNED} state_t;

    state_t           state, state_nxt;
    logic [N_REQ-1:0] grant_nxt;
    logic [HW-1:0]    hold_cnt, hold_nxt;
    logic [OW-1:0]    last_owner, last_nxt;
    logic [2:0]       color_reg, color_nxt;

    logic [N_REQ-1:0] owner_oh, cand;
    logic [OW-1:0]    pick_idx;
    logic             pick_ok;
    logic [2:0]       pick_color, own_color;
    logic             at_max, others, release_now;
    logic             gate;

    // While owned, last_owner is the current owner.
    assign owner_oh = N_REQ'(1) << last_owner;
    // On release the owner is always left out of the pick: under release (A)
    // its req is already low, so masking only matters for preemption.
    assign cand     = (state == OWNED) ? (bus.req & ~owner_oh) : bus.req;

    // Round-robin scan from last_owner+1; descending loop so the nearest
    // candidate is the one that sticks.
    always_comb begin
        logic [OW-1:0] pi;
        pick_ok  = 1'b0;
        pick_idx = last_owner;
        for (int k = N_REQ; k >= 1; k--) begin
            pi = OW'((int'(last_owner) + k) % N_REQ);
            if (cand[pi]) begin
                pick_ok  = 1'b1;
                pick_idx = pi;
            end
        end
    end

    always_comb begin
        pick_color = 3'b000;
        own_color  = 3'b000;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx == OW'(i))   pick_color = bus.color[3*i +: 3];
            if (last_owner == OW'(i)) own_color  = bus.color[3*i +: 3];
        end
    end

    assign at_max      = (hold_cnt == HW'(MAX_HOLD - 1));
    assign others      = |(bus.req & ~owner_oh);
    assign release_now = (state == OWNED) &&
                         ((!bus.req[last_owner] && hold_cnt >= HW'(MIN_HOLD - 1)) ||
                          (at_max && others));

    always_comb begin
        state_nxt = state;
        grant_nxt = bus.grant;
        hold_nxt  = hold_cnt;
        last_nxt  = last_owner;
        color_nxt = color_reg;
        if (state == IDLE || release_now) begin
            if (pick_ok) begin
                state_nxt = OWNED;
                grant_nxt = N_REQ'(1) << pick_idx;
                hold_nxt  = '0;
                last_nxt  = pick_idx;
                color_nxt = pick_color;
            end else begin
                state_nxt = IDLE;
                grant_nxt = '0;
                color_nxt = 3'b000;
            end
        end else begin
            if (!at_max) hold_nxt = hold_cnt + HW'(1);
            // Owner that dropped req keeps its last colour on the LED.
            if (bus.req[last_owner]) color_nxt = own_color;
        end
    end

`ifdef RGB_PWM_DIM_EN
    logic [PWM_BITS-1:0] pwm_cnt;
    always_ff @(posedge clk) begin
        if (rst) pwm_cnt <= '0;
        else     pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
    assign gate = (pwm_cnt < dim);
`else
    assign gate = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bus.grant  <= '0;
            bus.busy   <= 1'b0;
            hold_cnt   <= '0;
            last_owner <= OW'(N_REQ - 1);
            color_reg  <= 3'b000;
            RGB_R      <= 1'b1;
            RGB_G      <= 1'b1;
            RGB_B      <= 1'b1;
        end else begin
            state      <= state_nxt;
            bus.grant  <= grant_nxt;
            bus.busy   <= |grant_nxt;
            hold_cnt   <= hold_nxt;
            last_owner <= last_nxt;
            color_reg  <= color_nxt;
            // Pins load from color_nxt so they track color_reg with no extra stage.
            RGB_R      <= ~(color_nxt[2] & gate);
            RGB_G      <= ~(color_nxt[1] & gate);
            RGB_B      <= ~(color_nxt[0] & gate);
        end
    end
endmodule

// File: tb/tb_rgb_led_arbiter.sv
// tb_rgb_led_arbiter: directed stimulus for rgb_led_arbiter (N_REQ=3,
// MIN_HOLD=4, MAX_HOLD=10) with a behavioural model checked every cycle
// plus literal expectations per scenario.
module tb_rgb_led_arbiter;
    localparam int N = 3, MINH = 4, MAXH = 10;

    logic clk = 1'b0;
    logic rst;
    logic RGB_R, RGB_G, RGB_B;
    logic [3:0] dim;
    always #5 clk = ~clk;

    rgb_led_arbiter_if #(.N_REQ(N)) bus();

    rgb_led_arbiter #(.N_REQ(N), .MIN_HOLD(MINH), .MAX_HOLD(MAXH), .PWM_BITS(4)) dut (
        .clk(clk), .rst(rst), .bus(bus),
`ifdef RGB_PWM_DIM_EN
        .dim(dim),
`endif
        .RGB_R(RGB_R), .RGB_G(RGB_G), .RGB_B(RGB_B)
    );

    int tests = 0, fails = 0;

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_owner, m_held, m_last, m_pwm;
    logic [2:0] m_color, m_rgb;

    function automatic int rr(int last, logic [2:0] mask);
        for (int k = 1; k <= N; k++)
            if (mask[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    task automatic take(int p);
        m_owner = p;
        m_held  = 0;
        m_last  = p;
        m_color = bus.color[3*p +: 3];
    endtask

    always @(posedge clk) begin
        logic [2:0] r, oth;
        int p;
        logic g;
        r = bus.req;
        if (rst) begin
            m_owner = -1; m_held = 0; m_last = N - 1; m_color = 3'b000;
            m_rgb = 3'b111; m_pwm = 0;
        end else begin
            if (m_owner < 0) begin
                p = rr(m_last, r);
                if (p >= 0) take(p);
                else m_color = 3'b000;
            end else begin
                oth = r & ~(3'b001 << m_owner);
                if ((!r[m_owner] && m_held >= MINH - 1) || (m_held == MAXH - 1 && oth != 0)) begin
                    p = rr(m_last, oth);
                    if (p >= 0) take(p);
                    else begin m_owner = -1; m_color = 3'b000; end
                end else begin
                    if (m_held < MAXH - 1) m_held++;
                    if (r[m_owner]) m_color = bus.color[3*m_owner +: 3];
                end
            end
`ifdef RGB_PWM_DIM_EN
            g = (m_pwm < int'(dim));
            m_pwm = (m_pwm + 1) % 16;
`else
            g = 1'b1;
`endif
            m_rgb = ~(m_color & {3{g}});
        end
    end

    always @(negedge clk) begin
        chk("model_grant", bus.grant, (m_owner < 0) ? 0 : (1 << m_owner));
        chk("model_busy", bus.busy, (m_owner >= 0) ? 1 : 0);
        chk("model_rgb", {RGB_R, RGB_G, RGB_B}, m_rgb);
    end

    // ---------------- directed stimulus ----------------
    task automatic do_reset();
        rst = 1'b1; bus.req = 3'b000;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int cnt, n;
        logic [2:0] g, prev;
        logic [2:0] seq [3];
        int dur [3];

        rst = 1'b1; bus.req = 3'b111; bus.color = '0; dim = 4'd15;
        repeat (2) begin
            @(negedge clk);
            chk("rst_grant", bus.grant, 0);
            chk("rst_busy", bus.busy, 0);
            chk("rst_rgb", {RGB_R, RGB_G, RGB_B}, 3'b111);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("first_grant", bus.grant, 3'b001);

        // grant latency and colour tracking
        do_reset();
        bus.color = 9'b000_000_100; bus.req = 3'b001;
        @(negedge clk);
        chk("lat_grant", bus.grant, 3'b001);
        chk("lat_busy", bus.busy, 1);
        chk("lat_rgb", {RGB_R, RGB_G, RGB_B}, 3'b011);
        bus.color = 9'b000_000_011;
        @(negedge clk);
        chk("track_rgb", {RGB_R, RGB_G, RGB_B}, 3'b100);

        // minimum hold with a one-cycle request
        do_reset();
        bus.color = 9'b000_000_100; bus.req = 3'b001;
        @(negedge clk);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.grant == 3'b001 && {RGB_R, RGB_G, RGB_B} == 3'b011) cnt++;
            bus.req = 3'b000;
            @(negedge clk);
        end
        chk("minhold_cycles", cnt, 4);
        chk("minhold_idle_grant", bus.grant, 0);
        chk("minhold_idle_rgb", {RGB_R, RGB_G, RGB_B}, 3'b111);

        // preemption between req0 and req2
        do_reset();
        bus.color = 9'b001_000_100; bus.req = 3'b101;
        @(negedge clk);
        for (int i = 0; i < 25; i++) begin
            chk("preempt_seq", bus.grant, (i < 10 || i >= 20) ? 3'b001 : 3'b100);
            @(negedge clk);
        end

        // round-robin order, each req dropped after its grant
        do_reset();
        bus.color = 9'b001_010_100; bus.req = 3'b111;
        @(negedge clk);
        n = 0; prev = 3'b000;
        for (int j = 0; j < 3; j++) begin seq[j] = 3'b000; dur[j] = 0; end
        for (int i = 0; i < 16; i++) begin
            g = bus.grant;
            if (g != 3'b000) begin
                if (g != prev) begin
                    n++;
                    if (n <= 3) seq[n-1] = g;
                end
                if (n >= 1 && n <= 3) dur[n-1]++;
            end
            prev = g;
            bus.req = bus.req & ~g;
            @(negedge clk);
        end
        chk("rr_count", n, 3);
        chk("rr_seq0", seq[0], 3'b001);
        chk("rr_seq1", seq[1], 3'b010);
        chk("rr_seq2", seq[2], 3'b100);
        chk("rr_dur0", dur[0], 4);
        chk("rr_dur1", dur[1], 4);
        chk("rr_dur2", dur[2], 4);

        // reset during ownership
        do_reset();
        bus.req = 3'b010;
        repeat (3) @(negedge clk);
        chk("mid_owner", bus.grant, 3'b010);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_grant", bus.grant, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_rgb", {RGB_R, RGB_G, RGB_B}, 3'b111);
        rst = 1'b0; bus.req = 3'b011;
        @(negedge clk);
        chk("mid_next_pick", bus.grant, 3'b001);

`ifdef RGB_PWM_DIM_EN
        do_reset();
        dim = 4'd4; bus.color = 9'b000_000_100; bus.req = 3'b001;
        repeat (3) @(negedge clk);
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (RGB_R == 1'b0) cnt++;
            @(negedge clk);
        end
        chk("dim_red_duty", cnt, 4);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
